// File: rtl/dut_stream_pkg.sv
// Shared helpers for the DMA <-> DUT stream bridge: lane ratios,
// counter widths and lane bit-offset arithmetic.
package dut_stream_pkg;

  // Number of DUT input samples carried by one stream word.
  function automatic int unpack_ratio(input int axis_w, input int din_w);
    return axis_w / din_w;
  endfunction

  // Number of DUT output samples packed into one stream word.
  function automatic int pack_ratio(input int axis_w, input int dout_w);
    return axis_w / dout_w;
  endfunction

  // Width of an index that must hold values 0..n-1 (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy counter that must hold values 0..n.
  function automatic int occ_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Bit offset of a lane inside a word; lane 0 sits in the LSBs.
  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with occupancy output.
// A write while full is still taken when a read happens in the same
// cycle. Read data reads as zero while the FIFO is empty.
module stream_fifo
  import dut_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [occ_width(DEPTH)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             rd_fire;
  logic             wr_fire;

  assign count_o   = CW'(wr_ptr_q - rd_ptr_q);
  assign empty_o   = (count_o == '0);
  assign full_o    = (count_o == CW'(DEPTH));
  assign rd_fire   = rd_en_i & ~empty_o;
  assign wr_fire   = wr_en_i & (~full_o | rd_fire);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: each side advances on its own accepted transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers, cleared by reset so the FIFO starts empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty masks the output.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/dut_stream_bridge.sv
// Flow-controlled adapter between DMA AXI-Stream channels and a DUT.
// Input words are unpacked lane by lane into dut_din under dut_ce; DUT
// results are packed back into words, buffered in a FWFT FIFO and
// framed with tlast every frame_len beats (frame_len = 0: unframed).
// Handshakes: a transfer happens on a cycle where valid and ready are
// both high; valid never waits on ready, and dut_ce / s_axis_tready are
// built from registers and enable only, never from m_axis_tready.
module dut_stream_bridge
  import dut_stream_pkg::*;
#(
  parameter int AXIS_W     = 32,
  parameter int DIN_W      = 16,
  parameter int DOUT_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int HEADROOM   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CNT_W-1:0]    frame_len,
  input  logic [AXIS_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DIN_W-1:0]    dut_din,
  output logic                dut_ce,
  input  logic [DOUT_W-1:0]   dut_dout,
  input  logic                dut_dout_valid,
  output logic [AXIS_W-1:0]   m_axis_tdata,
  output logic [AXIS_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam int UNPACK = unpack_ratio(AXIS_W, DIN_W);
  localparam int PACK   = pack_ratio(AXIS_W, DOUT_W);
  localparam int UL_W   = idx_width(UNPACK);
  localparam int PL_W   = idx_width(PACK);
  localparam int FC_W   = occ_width(FIFO_DEPTH);
  localparam int SEL_W  = idx_width(AXIS_W);
  localparam int P_TOP  = lane_lsb(PACK - 1, DOUT_W);

  localparam logic [UL_W-1:0] U_LAST  = UL_W'(UNPACK - 1);
  localparam logic [PL_W-1:0] P_LAST  = PL_W'(PACK - 1);
  localparam logic [FC_W-1:0] DEPTH_C = FC_W'(FIFO_DEPTH);
  localparam logic [FC_W-1:0] HEAD_C  = FC_W'(HEADROOM);

  // Input side state
  logic [AXIS_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [UL_W-1:0]   lane_q, lane_d;
  logic              last_lane;
  logic              space_ok;
  logic [SEL_W-1:0]  din_sel;

  // Output side state
  logic [AXIS_W-1:0] pack_q, pack_d;
  logic [PL_W-1:0]   plane_q, plane_d;
  logic [SEL_W-1:0]  pack_sel;
  logic              pack_last;
  logic              push_req;
  logic [AXIS_W-1:0] push_word;
  logic              pop;
  logic              drop;

  // FIFO and framing
  logic [FC_W-1:0]   fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              m_hs;

  // ---------------- input side ----------------
  // HEADROOM words stay free so results already in the DUT pipeline
  // still find room once dut_ce stops.
  assign space_ok      = (DEPTH_C - fifo_count) > HEAD_C;
  assign dut_ce        = enable & hold_vld_q & space_ok;
  assign last_lane     = (lane_q == U_LAST);
  assign s_axis_tready = ~hold_vld_q | (dut_ce & last_lane);
  assign din_sel       = SEL_W'(lane_lsb(int'(lane_q), DIN_W));
  assign dut_din       = DIN_W'(hold_q >> din_sel);

  // Hold/lane next-state: lane steps on dut_ce, the hold word empties
  // after its last lane unless a new word is loaded in the same cycle.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    lane_d     = lane_q;
    if (dut_ce) begin
      lane_d = last_lane ? '0 : lane_q + UL_W'(1);
      if (last_lane) hold_vld_d = 1'b0;
    end
    if (s_axis_tvalid && s_axis_tready) begin
      hold_d     = s_axis_tdata;
      hold_vld_d = 1'b1;
    end
  end

  // Input side registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      lane_q     <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      lane_q     <= lane_d;
    end
  end

  // ---------------- output side ----------------
  assign pack_sel  = SEL_W'(lane_lsb(int'(plane_q), DOUT_W));
  assign pack_last = (plane_q == P_LAST);
  assign push_req  = dut_dout_valid & pack_last;
  assign pop       = ~fifo_empty & m_axis_tready;
  // A full FIFO still takes the word when it is popped in the same cycle.
  assign drop      = push_req & fifo_full & ~pop;

  // The final lane bypasses the pack register so the word is pushed the
  // same cycle its last sample arrives.
  always_comb begin
    push_word = pack_q;
    push_word[P_TOP +: DOUT_W] = dut_dout;
  end

  // Pack next-state: every result fills the current lane; the lane
  // returns to 0 after the last one whether or not the word was kept.
  always_comb begin
    pack_d  = pack_q;
    plane_d = plane_q;
    if (dut_dout_valid) begin
      pack_d[pack_sel +: DOUT_W] = dut_dout;
      plane_d = pack_last ? '0 : plane_q + PL_W'(1);
    end
  end

  // Pack registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q  <= '0;
      plane_q <= '0;
    end else begin
      pack_q  <= pack_d;
      plane_q <= plane_d;
    end
  end

  stream_fifo #(
    .WIDTH (AXIS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push_req),
    .wr_data_i (push_word),
    .rd_en_i   (pop),
    .rd_data_o (m_axis_tdata),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  // ---------------- framing ----------------
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tkeep  = '1;
  // frame_len is sampled live, so shrinking it mid-frame ends the frame
  // on the next beat that goes out.
  assign m_axis_tlast  = m_axis_tvalid & (frame_len != '0) &
                         (beat_q >= frame_len - CNT_W'(1));
  assign m_hs          = m_axis_tvalid & m_axis_tready;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;

  // Beat/frame/drop counter next-state; drop_cnt sticks at all-ones.
  always_comb begin
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (m_hs) begin
      if (m_axis_tlast) begin
        beat_d      = '0;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end else begin
        beat_d = beat_q + CNT_W'(1);
      end
    end
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q      <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_dut_stream_bridge.sv
// Self-checking bench for dut_stream_bridge. The bench plays the DMA
// source, the S2MM sink and an identity DUT with one cycle of latency,
// and keeps a queue-based reference model of samples, words and frames.
module tb_dut_stream_bridge;

  localparam int AXIS_W     = 32;
  localparam int DIN_W      = 16;
  localparam int DOUT_W     = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int HEADROOM   = 2;
  localparam int CNT_W      = 16;
  localparam int UNPACK     = AXIS_W / DIN_W;
  localparam int PACK       = AXIS_W / DOUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                enable;
  logic [CNT_W-1:0]    frame_len;
  logic [AXIS_W-1:0]   s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [DIN_W-1:0]    dut_din;
  logic                dut_ce;
  logic [DOUT_W-1:0]   dut_dout;
  logic                dut_dout_valid;
  logic [AXIS_W-1:0]   m_axis_tdata;
  logic [AXIS_W/8-1:0] m_axis_tkeep;
  logic                m_axis_tlast;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [CNT_W-1:0]    frame_cnt;
  logic [CNT_W-1:0]    drop_cnt;

  dut_stream_bridge #(
    .AXIS_W(AXIS_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .HEADROOM(HEADROOM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_len(frame_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .dut_din(dut_din), .dut_ce(dut_ce),
    .dut_dout(dut_dout), .dut_dout_valid(dut_dout_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [AXIS_W-1:0] src_q[$];   // words still to be offered on MM2S
  logic [DIN_W-1:0]  pend_q[$];  // accepted samples not yet strobed
  logic [DOUT_W-1:0] pk_q[$];    // results waiting to fill a word
  logic [AXIS_W-1:0] exp_q[$];   // expected FIFO contents, oldest first
  logic [DIN_W-1:0]  din_log[$];
  logic [AXIS_W-1:0] out_log[$];
  logic              last_log[$];
  int mbeat, mframes, mdrops;
  int total, bad;
  int dut_lasts, first_last_beat;
  bit ident, rand_valid, last_ce;
  int ready_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    src_q.delete(); pend_q.delete(); pk_q.delete(); exp_q.delete();
    mbeat = 0; mframes = 0; mdrops = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_src();
    if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = $urandom;
    end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: check at the falling edge, then apply the rising edge to
  // the model and drive the next inputs just after it.
  task automatic tick();
    logic exp_ce, exp_rdy, exp_last, s_hs, m_hs, ce_now, dv_now;
    logic [DOUT_W-1:0] dd_now, res_now;
    logic [AXIS_W-1:0] w;
    @(negedge clk);
    exp_ce   = enable && (pend_q.size() > 0) && ((FIFO_DEPTH - exp_q.size()) > HEADROOM);
    exp_rdy  = (pend_q.size() == 0) || (exp_ce && (pend_q.size() == 1));
    exp_last = (frame_len != '0) && (mbeat >= (int'(frame_len) - 1));
    chk("dut_ce", 64'(dut_ce), 64'(exp_ce));
    chk("s_ready", 64'(s_axis_tready), 64'(exp_rdy));
    chk("m_valid", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
    if (dut_ce && pend_q.size() > 0) chk("dut_din", 64'(dut_din), 64'(pend_q[0]));
    if (m_axis_tvalid && exp_q.size() > 0) begin
      chk("m_data", 64'(m_axis_tdata), 64'(exp_q[0]));
      chk("m_last", 64'(m_axis_tlast), 64'(exp_last));
    end
    s_hs    = s_axis_tvalid && s_axis_tready;
    m_hs    = m_axis_tvalid && m_axis_tready && (exp_q.size() > 0);
    ce_now  = dut_ce;
    dv_now  = dut_dout_valid;
    dd_now  = dut_dout;
    res_now = (pend_q.size() > 0) ? DOUT_W'(pend_q[0]) : '0;
    if (ce_now) din_log.push_back(dut_din);
    if (m_hs) begin
      out_log.push_back(m_axis_tdata);
      last_log.push_back(m_axis_tlast);
      if (m_axis_tlast) begin
        dut_lasts++;
        if (first_last_beat < 0) first_last_beat = mbeat;
      end
    end
    @(posedge clk);
    #1;
    // pop before push: a full FIFO popped this cycle still takes the word
    if (m_hs) begin
      void'(exp_q.pop_front());
      if (exp_last) begin mbeat = 0; mframes++; end
      else mbeat++;
    end
    if (dv_now) begin
      pk_q.push_back(dd_now);
      if (pk_q.size() == PACK) begin
        w = '0;
        for (int i = 0; i < PACK; i++) w = w | (AXIS_W'(pk_q[i]) << (i * DOUT_W));
        pk_q.delete();
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(w);
        else if (mdrops < (1 << CNT_W) - 1) mdrops++;
      end
    end
    if (ce_now && pend_q.size() > 0) void'(pend_q.pop_front());
    if (s_hs && src_q.size() > 0) begin
      w = src_q.pop_front();
      for (int i = 0; i < UNPACK; i++) pend_q.push_back(DIN_W'(w >> (i * DIN_W)));
    end
    if (ident) begin
      dut_dout_valid = ce_now;
      dut_dout       = res_now;
    end else begin
      dut_dout_valid = 1'b0;
    end
    last_ce = ce_now;
    drive_src();
    drive_ready();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() + pend_q.size() + exp_q.size() + int'(dut_dout_valid)) > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(src_q.size() + pend_q.size() + exp_q.size()), 64'(0));
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    s_axis_tvalid  = 1'b0;
    dut_dout_valid = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_axis_tready), 64'(1));
    chk("rst_ce", 64'(dut_ce), 64'(0));
    chk("rst_din", 64'(dut_din), 64'(0));
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_m_last", 64'(m_axis_tlast), 64'(0));
    chk("rst_m_data", 64'(m_axis_tdata), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    model_clear();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", 64'(s_axis_tready), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    total = 0; bad = 0; dut_lasts = 0; first_last_beat = -1;
    rst = 1'b1; enable = 1'b0; frame_len = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; dut_dout = '0; dut_dout_valid = 1'b0;
    m_axis_tready = 1'b0; ident = 1'b1; rand_valid = 1'b0; ready_mode = 1; last_ce = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Directed identity run, two-beat frames.
    frame_len = CNT_W'(2); enable = 1'b1; ready_mode = 1; drive_ready();
    din_log.delete(); out_log.delete(); last_log.delete();
    src_q.push_back(32'h0002_0001);
    src_q.push_back(32'h0004_0003);
    drive_src();
    drain(40);
    for (int k = 0; k < 4; k++) chk($sformatf("id_din%0d", k), 64'(din_log[k]), 64'(k + 1));
    chk("id_word0", 64'(out_log[0]), 64'(32'h0002_0001));
    chk("id_word1", 64'(out_log[1]), 64'(32'h0004_0003));
    chk("id_last0", 64'(last_log[0]), 64'(0));
    chk("id_last1", 64'(last_log[1]), 64'(1));
    chk("id_frame_cnt", 64'(frame_cnt), 64'(1));

    // Randomized traffic with random valid/ready and short frames.
    frame_len = CNT_W'($urandom_range(1, 5)); rand_valid = 1'b1; ready_mode = 2;
    for (int k = 0; k < 40; k++) src_q.push_back($urandom);
    drain(2000);
    chk("rnd_frame_cnt", 64'(frame_cnt), 64'(mframes));
    chk("rnd_drop_cnt", 64'(drop_cnt), 64'(mdrops));

    // Backpressure: sink stalled, input must stop once headroom is reached.
    rand_valid = 1'b0; ready_mode = 0; drive_ready();
    for (int k = 0; k < 20; k++) src_q.push_back($urandom);
    repeat (60) tick();
    chk("bp_ce", 64'(dut_ce), 64'(0));
    chk("bp_s_ready", 64'(s_axis_tready), 64'(0));
    chk("bp_m_valid", 64'(m_axis_tvalid), 64'(1));
    chk("bp_drop_cnt", 64'(drop_cnt), 64'(0));

    // Forced drop: fill the FIFO with hand-driven results, then one more word.
    enable = 1'b0;
    repeat (3) tick();
    ident = 1'b0;
    n = 0;
    while (exp_q.size() < FIFO_DEPTH && n < 60) begin
      dut_dout_valid = 1'b1; dut_dout = DOUT_W'($urandom);
      tick();
      n++;
    end
    repeat (2) begin
      dut_dout_valid = 1'b1; dut_dout = DOUT_W'($urandom);
      tick();
    end
    tick();
    chk("drop_cnt_one", 64'(drop_cnt), 64'(1));
    chk("drop_model", 64'(drop_cnt), 64'(mdrops));
    ident = 1'b1; enable = 1'b1; ready_mode = 2; rand_valid = 1'b1;
    drain(2000);
    chk("drop_frame_cnt", 64'(frame_cnt), 64'(mframes));

    // Reset in the middle of traffic.
    for (int k = 0; k < 10; k++) src_q.push_back($urandom);
    repeat (15) tick();
    do_reset();

    // Unframed: no tlast over more than 100 beats.
    frame_len = '0; rand_valid = 1'b0; ready_mode = 1; dut_lasts = 0;
    for (int k = 0; k < 110; k++) src_q.push_back($urandom);
    drive_src(); drive_ready();
    drain(1500);
    chk("unframed_tlast", 64'(dut_lasts), 64'(0));
    chk("unframed_frames", 64'(frame_cnt), 64'(0));

    // Live frame_len change: 8, shrunk to 3 after five beats.
    do_reset();
    frame_len = CNT_W'(8); first_last_beat = -1; dut_lasts = 0;
    for (int k = 0; k < 12; k++) src_q.push_back($urandom);
    drive_src(); drive_ready();
    n = 0;
    while (mbeat < 5 && n < 100) begin tick(); n++; end
    frame_len = CNT_W'(3);
    drain(500);
    chk("shrink_tlast_beat", 64'(first_last_beat), 64'(5));
    chk("shrink_frames", 64'(frame_cnt), 64'(mframes));
    chk("shrink_lasts", 64'(dut_lasts), 64'(mframes));

    // Enable dropped after lane 0; lane 1 must be presented next.
    src_q.push_back(32'hBBBB_AAAA);
    drive_src();
    last_ce = 1'b0; n = 0;
    while (!last_ce && n < 20) begin tick(); n++; end
    enable = 1'b0;
    chk("en_lane0_seen", 64'(last_ce), 64'(1));
    repeat (4) tick();
    chk("en_hold_din", 64'(dut_din), 64'(16'hBBBB));
    chk("en_hold_ce", 64'(dut_ce), 64'(0));
    enable = 1'b1;
    drain(100);
    chk("en_frames", 64'(frame_cnt), 64'(mframes));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
